// File: rtl/apb_cmd_sequencer.sv
// apb_cmd_sequencer: buffers write/read requests from a valid/ready port and
// replays them one at a time onto apb_top's add_i/external_wdata_i pins.
// Read data is returned on a single-entry valid/ready response slot.
module apb_cmd_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                   pclk,
    input  logic                   preset_n,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   cmd_write_i,
    input  logic [DATA_W-1:0]      cmd_wdata_i,
    output logic [1:0]             add_o,
    output logic [DATA_W-1:0]      external_wdata_o,
    input  logic                   ready_i,
    input  logic [DATA_W-1:0]      rdata_i,
    output logic                   rsp_valid_o,
    output logic [DATA_W-1:0]      rsp_data_o,
    input  logic                   rsp_ready_i,
    output logic                   busy_o,
    output logic                   err_o,
    output logic [$clog2(DEPTH):0] cmd_count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT);

    localparam logic [1:0] ADD_IDLE  = 2'b00;
    localparam logic [1:0] ADD_READ  = 2'b01;
    localparam logic [1:0] ADD_WRITE = 2'b11;

    typedef struct packed {
        logic              write;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_RELEASE
    } state_t;

    cmd_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    state_t           state_q;
    logic [1:0]       add_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic             rsp_valid_q;
    logic             err_q;
    logic [TMO_W-1:0] tmo_q;

    cmd_t head;
    logic full;
    logic empty;
    logic push;
    logic pop;

    // A read at the head waits for the response slot; writes never wait on it.
    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = cmd_valid_i && !full;
    assign pop   = (state_q == S_IDLE) && !empty && (head.write || !rsp_valid_q);

    assign cmd_ready_o      = !full;
    assign cmd_count_o      = count_q;
    assign add_o            = add_q;
    assign external_wdata_o = wdata_q;
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_data_o       = rsp_data_q;
    assign err_o            = err_q;
    assign busy_o           = (state_q != S_IDLE);

    // Next-state for FIFO pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // FIFO pointer and occupancy registers.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge pclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{write: cmd_write_i, wdata: cmd_wdata_i};
        end
    end

    // Issue / wait-for-ready / release sequencer with registered outputs.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q     <= S_IDLE;
            add_q       <= ADD_IDLE;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
            tmo_q       <= '0;
        end else begin
            if (rsp_valid_q && rsp_ready_i) begin
                rsp_valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        add_q   <= head.write ? ADD_WRITE : ADD_READ;
                        tmo_q   <= '0;
                        state_q <= S_ACTIVE;
                        if (head.write) begin
                            wdata_q <= head.wdata;
                        end
                    end
                end
                S_ACTIVE: begin
                    tmo_q <= tmo_q + TMO_W'(1);
                    if (ready_i) begin
                        if (add_q == ADD_READ) begin
                            rsp_data_q  <= rdata_i;
                            rsp_valid_q <= 1'b1;
                        end
                        add_q   <= ADD_IDLE;
                        state_q <= S_RELEASE;
                    end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        add_q   <= ADD_IDLE;
                        state_q <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    add_q   <= ADD_IDLE;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// tb_apb_cmd_sequencer: directed and randomized checks of apb_cmd_sequencer
// against a transaction-level model of the command queue, the apb_top
// handshake and the response slot.
module tb_apb_cmd_sequencer;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

    logic              pclk = 1'b0;
    logic              preset_n;
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_write_i;
    logic [DATA_W-1:0] cmd_wdata_i;
    logic [1:0]        add_o;
    logic [DATA_W-1:0] external_wdata_o;
    logic              ready_i;
    logic [DATA_W-1:0] rdata_i;
    logic              rsp_valid_o;
    logic [DATA_W-1:0] rsp_data_o;
    logic              rsp_ready_i;
    logic              busy_o;
    logic              err_o;
    logic [CNT_W-1:0]  cmd_count_o;

    always #5 pclk = ~pclk;

    apb_cmd_sequencer #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .pclk            (pclk),
        .preset_n        (preset_n),
        .cmd_valid_i     (cmd_valid_i),
        .cmd_ready_o     (cmd_ready_o),
        .cmd_write_i     (cmd_write_i),
        .cmd_wdata_i     (cmd_wdata_i),
        .add_o           (add_o),
        .external_wdata_o(external_wdata_o),
        .ready_i         (ready_i),
        .rdata_i         (rdata_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_data_o      (rsp_data_o),
        .rsp_ready_i     (rsp_ready_i),
        .busy_o          (busy_o),
        .err_o           (err_o),
        .cmd_count_o     (cmd_count_o)
    );

    typedef struct {
        bit                wr;
        logic [DATA_W-1:0] d;
    } cmd_t;

    int n_chk;
    int n_fail;

    // Reference model state
    cmd_t              q[$];
    bit                act;
    bit                act_wr;
    int                act_k;
    int                act_lat;
    int                since_done;
    bit                rsp_pend;
    logic [DATA_W-1:0] rsp_exp;
    bit                err_exp;
    logic [DATA_W-1:0] last_wd;
    bit                will_issue;
    bit                done_pend;
    bit                done_rd;
    bit                done_tmo;
    logic [DATA_W-1:0] done_data;
    bit                drain_pend;
    bit                push_pend;
    cmd_t              push_item;

    // Stimulus controls
    bit                drv_valid;
    bit                drv_write;
    logic [DATA_W-1:0] drv_data;
    bit                drv_rsp_ready;
    bit                rand_mode;
    int                lat_sel;
    bit                rdata_fix;
    logic [DATA_W-1:0] rdata_val;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        act        = 1'b0;
        act_wr     = 1'b0;
        act_k      = 0;
        act_lat    = 1;
        since_done = 2;
        rsp_pend   = 1'b0;
        rsp_exp    = '0;
        err_exp    = 1'b0;
        last_wd    = '0;
        will_issue = 1'b0;
        done_pend  = 1'b0;
        done_rd    = 1'b0;
        done_tmo   = 1'b0;
        done_data  = '0;
        drain_pend = 1'b0;
        push_pend  = 1'b0;
    endtask

    // One model cycle, run on the falling edge: account for the rising edge
    // that just passed, compare, then choose inputs for the next rising edge.
    task automatic step();
        cmd_t head;
        if (drain_pend) rsp_pend = 1'b0;
        if (done_pend) begin
            check_eq("complete_add", 32'(add_o), 32'd0);
            act        = 1'b0;
            since_done = 1;
            if (done_rd) begin
                rsp_pend = 1'b1;
                rsp_exp  = done_data;
            end
            if (done_tmo) err_exp = 1'b1;
        end else if (will_issue) begin
            head = q.pop_front();
            check_eq("issue_add", 32'(add_o), head.wr ? 32'd3 : 32'd1);
            if (head.wr) last_wd = head.d;
            act    = 1'b1;
            act_wr = head.wr;
            act_k  = 1;
            if (lat_sel >= 0) act_lat = lat_sel;
            else act_lat = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 4));
        end else if (act) begin
            act_k++;
            check_eq("hold_add", 32'(add_o), act_wr ? 32'd3 : 32'd1);
        end else begin
            if (since_done < 2) since_done++;
            check_eq("idle_add", 32'(add_o), 32'd0);
        end
        if (push_pend) q.push_back(push_item);

        check_eq("count", 32'(cmd_count_o), 32'(q.size()));
        check_eq("cmd_ready", 32'(cmd_ready_o), 32'(q.size() != DEPTH));
        check_eq("rsp_valid", 32'(rsp_valid_o), 32'(rsp_pend));
        check_eq("rsp_data", rsp_data_o, rsp_exp);
        check_eq("err", 32'(err_o), 32'(err_exp));
        check_eq("ext_wdata", external_wdata_o, last_wd);
        check_eq("busy", 32'(busy_o), 32'(act || since_done == 1));

        will_issue = !act && since_done >= 2 && q.size() > 0 && (q[0].wr || !rsp_pend);
        done_pend  = 1'b0;
        done_rd    = 1'b0;
        done_tmo   = 1'b0;
        ready_i    = 1'b0;
        rdata_i    = rdata_fix ? rdata_val : DATA_W'($urandom());
        if (act) begin
            if (act_lat != 0 && act_k == act_lat) begin
                ready_i   = 1'b1;
                done_pend = 1'b1;
                done_rd   = !act_wr;
                done_data = rdata_i;
            end else if (act_lat == 0 && act_k == int'(TIMEOUT)) begin
                done_pend = 1'b1;
                done_tmo  = 1'b1;
            end
        end
        if (rand_mode) begin
            drv_valid     = ($urandom_range(0, 9) < 4);
            drv_write     = 1'($urandom_range(0, 1));
            drv_data      = DATA_W'($urandom());
            drv_rsp_ready = 1'($urandom_range(0, 1));
        end
        cmd_valid_i  = drv_valid;
        cmd_write_i  = drv_write;
        cmd_wdata_i  = drv_data;
        rsp_ready_i  = drv_rsp_ready;
        drain_pend   = rsp_pend && drv_rsp_ready;
        push_pend    = drv_valid && (q.size() != DEPTH);
        push_item.wr = drv_write;
        push_item.d  = drv_data;
    endtask

    task automatic tick();
        @(negedge pclk);
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Hold a request until the model sees it accepted.
    task automatic push_cmd(input bit wr, input logic [DATA_W-1:0] d);
        bit ok;
        ok        = 1'b0;
        drv_valid = 1'b1;
        drv_write = wr;
        drv_data  = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick();
            ok = push_pend;
        end
        drv_valid = 1'b0;
        check_eq("push_accept", 32'(ok), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        n_chk         = 0;
        n_fail        = 0;
        drv_valid     = 1'b0;
        drv_write     = 1'b0;
        drv_data      = '0;
        drv_rsp_ready = 1'b1;
        rand_mode     = 1'b0;
        lat_sel       = 3;
        rdata_fix     = 1'b0;
        rdata_val     = '0;
        preset_n      = 1'b0;
        cmd_valid_i   = 1'b0;
        cmd_write_i   = 1'b0;
        cmd_wdata_i   = '0;
        ready_i       = 1'b0;
        rdata_i       = '0;
        rsp_ready_i   = 1'b0;
        model_reset();

        #12;
        check_eq("reset_add", 32'(add_o), 32'd0);
        check_eq("reset_ext", external_wdata_o, 32'd0);
        check_eq("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check_eq("reset_rsp_data", rsp_data_o, 32'd0);
        check_eq("reset_busy", 32'(busy_o), 32'd0);
        check_eq("reset_err", 32'(err_o), 32'd0);
        check_eq("reset_count", 32'(cmd_count_o), 32'd0);
        check_eq("reset_cmd_ready", 32'(cmd_ready_o), 32'd1);

        @(negedge pclk);
        preset_n = 1'b1;
        step();
        idle(3);

        // Single write, apb_top answers 3 cycles into the transfer.
        lat_sel = 3;
        push_cmd(1'b1, 32'hDEADBEEF);
        idle(10);

        // Write then read returning the same word.
        rdata_fix = 1'b1;
        rdata_val = 32'hDEADBEEF;
        lat_sel   = 2;
        push_cmd(1'b1, 32'hDEADBEEF);
        push_cmd(1'b0, 32'h0);
        idle(12);
        rdata_fix = 1'b0;

        // Five commands against a slow apb_top: the FIFO fills.
        lat_sel = 10;
        push_cmd(1'b1, 32'h1111_0001);
        push_cmd(1'b1, 32'h2222_0002);
        push_cmd(1'b0, 32'h0);
        push_cmd(1'b1, 32'h4444_0004);
        push_cmd(1'b1, 32'h5555_0005);
        idle(80);

        // Two reads with the consumer stalled: the second must wait.
        lat_sel       = 1;
        drv_rsp_ready = 1'b0;
        push_cmd(1'b0, 32'h0);
        push_cmd(1'b0, 32'h0);
        idle(15);
        drv_rsp_ready = 1'b1;
        idle(10);

        // apb_top never answers: timeout, then the next command proceeds.
        lat_sel = 0;
        push_cmd(1'b1, 32'hA5A5_5A5A);
        idle(TIMEOUT + 5);
        lat_sel = 2;
        push_cmd(1'b1, 32'h0BAD_F00D);
        idle(8);

        // Randomized traffic.
        rand_mode = 1'b1;
        lat_sel   = -1;
        idle(3000);
        rand_mode     = 1'b0;
        drv_valid     = 1'b0;
        drv_rsp_ready = 1'b1;
        idle(80);

        // Reset while a read is on the bus, with commands still queued.
        lat_sel = 0;
        push_cmd(1'b0, 32'h0);
        push_cmd(1'b1, 32'h7777_0007);
        push_cmd(1'b1, 32'h8888_0008);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            found = (add_o == 2'b01);
        end
        check_eq("reset_found_read", 32'(found), 32'd1);
        #2;
        preset_n    = 1'b0;
        cmd_valid_i = 1'b0;
        ready_i     = 1'b0;
        #1;
        check_eq("async_reset_add", 32'(add_o), 32'd0);
        check_eq("async_reset_count", 32'(cmd_count_o), 32'd0);
        check_eq("async_reset_busy", 32'(busy_o), 32'd0);
        check_eq("async_reset_ready", 32'(cmd_ready_o), 32'd1);
        model_reset();
        drv_valid = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        preset_n = 1'b1;
        step();
        idle(3);
        lat_sel = 1;
        push_cmd(1'b1, 32'hC0DE_0001);
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
